// File: rtl/shift_add_multiplier_if.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier_if
// Purpose : request/result bundle of the shift-add multiplier.
// Signals : start           - begin a multiply (sampled on clk rising edge)
//           signed_mode     - 1 = two's-complement operands, 0 = unsigned
//           multiplicand_in - operand M, WIDTH bits
//           multiplier_in   - operand Q, WIDTH bits
//           busy            - high while the multiplier iterates
//           done            - one-cycle pulse when a result is written
//           product_out     - 2*WIDTH-bit result, held until the next result
// Modports: master drives the request and reads the result; slave is the
//           multiplier itself.
// ---------------------------------------------------------------------------
interface shift_add_multiplier_if #(
  parameter int WIDTH = 8
);
  logic                   start;
  logic                   signed_mode;
  logic [WIDTH-1:0]       multiplicand_in;
  logic [WIDTH-1:0]       multiplier_in;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     product_out;

  modport master (
    output start, signed_mode, multiplicand_in, multiplier_in,
    input  busy, done, product_out
  );

  modport slave (
    input  start, signed_mode, multiplicand_in, multiplier_in,
    output busy, done, product_out
  );
endinterface

// File: rtl/shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier
// Purpose : sequential radix-2 shift-and-add multiplier. Signed operands are
//           converted to magnitudes, multiplied unsigned over WIDTH cycles,
//           and the result is negated when the operand signs differ.
// Ports   : clk - clock, rising edge
//           rst - asynchronous active-high reset
//           bus - shift_add_multiplier_if.slave (start, signed_mode,
//                 multiplicand_in, multiplier_in, busy, done, product_out)
// Timing  : start captured at edge 0; WIDTH CALC cycles follow; the result is
//           written and done pulses after edge WIDTH.
// ---------------------------------------------------------------------------
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  shift_add_multiplier_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Magnitude of a two's-complement value as an unsigned WIDTH-bit number.
  // The most negative value maps to 2^(WIDTH-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      magnitude = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      magnitude = v;
    end
  endfunction

  // Two's-complement negation of a full-width product.
  function automatic logic [2*WIDTH-1:0] negate(input logic [2*WIDTH-1:0] v);
    negate = ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_t               state_q, state_d;
  logic [WIDTH:0]       a_q, a_d;        // accumulator with carry bit
  logic [WIDTH-1:0]     m_q, m_d;        // multiplicand magnitude
  logic [WIDTH-1:0]     q_q, q_d;        // multiplier, shifted right each cycle
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH:0]       sum_s;
  logic [WIDTH:0]       a_next_s;
  logic [WIDTH-1:0]     q_next_s;
  logic [2*WIDTH-1:0]   raw_product_s;

  // One iteration: conditional add into A, then shift {A,Q} right with 0 in.
  always_comb begin
    if (q_q[0]) begin
      sum_s = a_q + {1'b0, m_q};
    end else begin
      sum_s = a_q;
    end
    a_next_s      = {1'b0, sum_s[WIDTH:1]};
    q_next_s      = {sum_s[0], q_q[WIDTH-1:1]};
    raw_product_s = {a_next_s[WIDTH-1:0], q_next_s};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    m_d       = m_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_CALC;
          a_d     = {(WIDTH+1){1'b0}};
          cnt_d   = {CW{1'b0}};
          if (bus.signed_mode) begin
            m_d   = magnitude(bus.multiplicand_in);
            q_d   = magnitude(bus.multiplier_in);
            neg_d = bus.multiplicand_in[WIDTH-1] ^ bus.multiplier_in[WIDTH-1];
          end else begin
            m_d   = bus.multiplicand_in;
            q_d   = bus.multiplier_in;
            neg_d = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      // start is deliberately not looked at here: requests while busy are dropped.
      S_CALC: begin
        a_d   = a_next_s;
        q_d   = q_next_s;
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
          if (neg_q) begin
            product_d = negate(raw_product_s);
          end else begin
            product_d = raw_product_s;
          end
        end else begin
          state_d = S_CALC;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= {(WIDTH+1){1'b0}};
      m_q       <= {WIDTH{1'b0}};
      q_q       <= {WIDTH{1'b0}};
      cnt_q     <= {CW{1'b0}};
      neg_q     <= 1'b0;
      product_q <= {(2*WIDTH){1'b0}};
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      m_q       <= m_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign bus.busy        = (state_q == S_CALC);
  assign bus.done        = (state_q == S_DONE);
  assign bus.product_out = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// tb_shift_add_multiplier
// Self-checking bench for shift_add_multiplier at WIDTH=8: a table of
// operand/result records plus hand-written sequences for mid-operation
// start, back-to-back start held high, and reset during an operation.
// ---------------------------------------------------------------------------
module tb_shift_add_multiplier;

  localparam int W = 8;

  logic clk;
  logic rst;

  shift_add_multiplier_if #(.WIDTH(W)) bus ();

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string          name;
    logic           sm;
    logic [W-1:0]   m;
    logic [W-1:0]   q;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t           vecs[11];
  logic [2*W-1:0] sb[$];
  logic [2*W-1:0] last_prod;
  int             total;
  int             bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Entered at the negedge right after the capture edge. Scrambles operands
  // (they must no longer matter), optionally pulses start mid-operation,
  // and returns at the negedge on which done is first seen.
  task automatic wait_done(input string name, input int pulse_at);
    int             cyc;
    int             bcnt;
    logic [2*W-1:0] exp;
    cyc  = 0;
    bcnt = 0;
    bus.multiplicand_in = W'($urandom);
    bus.multiplier_in   = W'($urandom);
    bus.signed_mode     = ~bus.signed_mode;
    check({name, "_hold"}, 32'(bus.product_out), 32'(last_prod));
    while (!bus.done && cyc < 40) begin
      if (bus.busy) bcnt++;
      if (pulse_at >= 0 && cyc == pulse_at) begin
        bus.start           = 1'b1;
        bus.multiplicand_in = 8'h05;
        bus.multiplier_in   = 8'h05;
        bus.signed_mode     = 1'b1;
      end else if (pulse_at >= 0 && cyc == pulse_at + 1) begin
        bus.start = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    check({name, "_latency"}, 32'(cyc), 32'd8);
    check({name, "_busy_cycles"}, 32'(bcnt), 32'd8);
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      check({name, "_product"}, 32'(bus.product_out), 32'(exp));
      last_prod = exp;
    end else begin
      check({name, "_scoreboard_empty"}, 32'd0, 32'd1);
    end
  endtask

  // Issue one start pulse from a negedge and run the operation to completion.
  task automatic run_op(input string name, input logic sm, input logic [W-1:0] m,
                        input logic [W-1:0] q, input logic [2*W-1:0] exp);
    bus.start           = 1'b1;
    bus.signed_mode     = sm;
    bus.multiplicand_in = m;
    bus.multiplier_in   = q;
    sb.push_back(exp);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(name, -1);
    @(negedge clk);
    check({name, "_done_pulse"}, {30'd0, bus.done, bus.busy}, 32'd0);
  endtask

  initial begin
    int seen_done;
    total = 0;
    bad   = 0;
    last_prod = 16'h0000;

    vecs[0]  = '{"u_13x11",   1'b0, 8'd13,  8'd11,  16'h008F};
    vecs[1]  = '{"u_255x255", 1'b0, 8'hFF,  8'hFF,  16'hFE01};
    vecs[2]  = '{"s_m3x5",    1'b1, 8'hFD,  8'h05,  16'hFFF1};
    vecs[3]  = '{"s_m128sq",  1'b1, 8'h80,  8'h80,  16'h4000};
    vecs[4]  = '{"s_127xm128",1'b1, 8'h7F,  8'h80,  16'hC080};
    vecs[5]  = '{"u_0x200",   1'b0, 8'h00,  8'd200, 16'h0000};
    vecs[6]  = '{"s_m3x0",    1'b1, 8'hFD,  8'h00,  16'h0000};
    vecs[7]  = '{"s_m1xm1",   1'b1, 8'hFF,  8'hFF,  16'h0001};
    vecs[8]  = '{"u_128x2",   1'b0, 8'h80,  8'h02,  16'h0100};
    vecs[9]  = '{"s_m128x1",  1'b1, 8'h80,  8'h01,  16'hFF80};
    vecs[10] = '{"u_253x5",   1'b0, 8'hFD,  8'h05,  16'h04F1};

    rst                 = 1'b1;
    bus.start           = 1'b0;
    bus.signed_mode     = 1'b0;
    bus.multiplicand_in = 8'h00;
    bus.multiplier_in   = 8'h00;
    #1;
    check("reset_busy",    32'(bus.busy),        32'd0);
    check("reset_done",    32'(bus.done),        32'd0);
    check("reset_product", 32'(bus.product_out), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven operations.
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].name, vecs[i].sm, vecs[i].m, vecs[i].q, vecs[i].exp);
    end

    // 7 x 9 with a second start pulse (different operands) mid-operation.
    bus.start           = 1'b1;
    bus.signed_mode     = 1'b0;
    bus.multiplicand_in = 8'd7;
    bus.multiplier_in   = 8'd9;
    sb.push_back(16'h003F);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("restart_ignored", 3);
    @(negedge clk);
    check("restart_ignored_after", {30'd0, bus.done, bus.busy}, 32'd0);

    // start held high across DONE: 3 x 4 then 6 x 7 back to back.
    bus.start           = 1'b1;
    bus.signed_mode     = 1'b0;
    bus.multiplicand_in = 8'd3;
    bus.multiplier_in   = 8'd4;
    sb.push_back(16'd12);
    @(negedge clk);
    wait_done("b2b_a", -1);
    bus.multiplicand_in = 8'd6;
    bus.multiplier_in   = 8'd7;
    bus.signed_mode     = 1'b0;
    sb.push_back(16'd42);
    @(negedge clk);
    check("b2b_no_idle", {30'd0, bus.done, bus.busy}, 32'd1);
    wait_done("b2b_b", -1);
    bus.start = 1'b0;
    @(negedge clk);
    check("b2b_end", {30'd0, bus.done, bus.busy}, 32'd0);

    // Reset during 100 x 100, then a fresh 2 x 3.
    bus.start           = 1'b1;
    bus.signed_mode     = 1'b0;
    bus.multiplicand_in = 8'd100;
    bus.multiplier_in   = 8'd100;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_prebusy", 32'(bus.busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_busy",    32'(bus.busy),        32'd0);
    check("abort_done",    32'(bus.done),        32'd0);
    check("abort_product", 32'(bus.product_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_prod = 16'h0000;
    seen_done = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.done || bus.product_out != 16'h0000) seen_done = 1;
      @(negedge clk);
    end
    check("abort_no_done", 32'(seen_done), 32'd0);
    run_op("post_reset_2x3", 1'b0, 8'd2, 8'd3, 16'h0006);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
